// File: rtl/tp_frame_capture.sv
// tp_frame_capture: arms on sig_en_i, captures one complete video frame
// (pixel data plus column/row coordinates), reports line length, flags
// counter saturation and drives a registered MODE-selected logic output.
module tp_frame_capture #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned X_WIDTH    = 12,
    parameter int unsigned Y_WIDTH    = 12,
    parameter int unsigned MODE       = 0
) (
    input  logic                  sig_clock,
    input  logic                  sig_reset,
    input  logic                  sig_en_i,
    input  logic                  sig_ina,
    input  logic                  sig_inb,
    input  logic                  iFValid,
    input  logic                  iLValid,
    input  logic [DATA_WIDTH-1:0] idata,
    output logic                  oFValid,
    output logic                  oLValid,
    output logic [DATA_WIDTH-1:0] odata,
    output logic [X_WIDTH-1:0]    ox,
    output logic [Y_WIDTH-1:0]    oy,
    output logic                  sig_en_o,
    output logic                  sig_out,
    output logic                  frame_done,
    output logic [X_WIDTH-1:0]    line_pixels,
    output logic                  ovf
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_FS = 2'd1,
        ACTIVE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [X_WIDTH-1:0] X_MAX = '1;
    localparam logic [Y_WIDTH-1:0] Y_MAX = '1;

    state_t                  state_q, state_d;
    logic                    fv_prev_q, fv_prev_d;
    logic                    lv_prev_q, lv_prev_d;
    logic [X_WIDTH-1:0]      xcnt_q, xcnt_d;
    logic [Y_WIDTH-1:0]      ycnt_q, ycnt_d;
    logic                    ofv_q, ofv_d;
    logic                    olv_q, olv_d;
    logic [DATA_WIDTH-1:0]   odata_q, odata_d;
    logic [X_WIDTH-1:0]      ox_q, ox_d;
    logic [Y_WIDTH-1:0]      oy_q, oy_d;
    logic                    sig_en_o_q, sig_en_o_d;
    logic                    sig_out_q, sig_out_d;
    logic                    frame_done_q, frame_done_d;
    logic [X_WIDTH-1:0]      line_pixels_q, line_pixels_d;
    logic                    ovf_q, ovf_d;

    // Edge detects and capture-window qualification
    logic               fv_rise, fv_fall;
    logic               frame_start, window, pixel, line_end;
    logic [X_WIDTH-1:0] x_base;
    logic [Y_WIDTH-1:0] y_base;

    // Next-state, counter and output computation
    always_comb begin
        state_d       = state_q;
        fv_prev_d     = iFValid;
        lv_prev_d     = iLValid;
        xcnt_d        = xcnt_q;
        ycnt_d        = ycnt_q;
        ofv_d         = 1'b0;
        olv_d         = 1'b0;
        odata_d       = '0;
        ox_d          = ox_q;
        oy_d          = oy_q;
        line_pixels_d = line_pixels_q;
        ovf_d         = ovf_q;
        sig_out_d     = 1'b0;

        fv_rise     = iFValid & ~fv_prev_q;
        fv_fall     = ~iFValid & fv_prev_q;
        frame_start = (state_q == WAIT_FS) & fv_rise;
        window      = iFValid & ((state_q == ACTIVE) | frame_start);
        pixel       = window & iLValid;
        // A line also ends when the frame drops while the line was still open
        line_end    = (window & ~iLValid & lv_prev_q)
                    | ((state_q == ACTIVE) & fv_fall & (lv_prev_q | iLValid));

        // Frame start restarts the counters before this cycle is counted
        x_base = frame_start ? '0 : xcnt_q;
        y_base = frame_start ? '0 : ycnt_q;
        if (frame_start) begin
            xcnt_d = '0;
            ycnt_d = '0;
            ovf_d  = 1'b0;
        end

        ofv_d = window;
        olv_d = pixel;
        if (pixel) begin
            odata_d = idata;
            ox_d    = x_base;
            oy_d    = y_base;
            if (x_base == X_MAX) begin
                ovf_d = 1'b1;
            end else begin
                xcnt_d = x_base + X_WIDTH'(1);
            end
        end

        if (line_end) begin
            line_pixels_d = x_base;
            xcnt_d        = '0;
            if (y_base == Y_MAX) begin
                ovf_d = 1'b1;
            end else begin
                ycnt_d = y_base + Y_WIDTH'(1);
            end
        end

        case (state_q)
            IDLE:    if (sig_en_i) state_d = WAIT_FS;
            WAIT_FS: if (frame_start) state_d = ACTIVE;
            ACTIVE:  if (fv_fall) state_d = DONE;
            DONE:    state_d = sig_en_i ? WAIT_FS : IDLE;
            default: state_d = IDLE;
        endcase

        sig_en_o_d   = (state_d == ACTIVE);
        frame_done_d = (state_d == DONE);

        case (MODE)
            0:       sig_out_d = sig_ina & sig_inb;
            1:       sig_out_d = sig_ina | sig_inb;
            2:       sig_out_d = sig_ina ^ sig_inb;
            default: sig_out_d = sig_ina;
        endcase
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            state_q       <= IDLE;
            fv_prev_q     <= 1'b0;
            lv_prev_q     <= 1'b0;
            xcnt_q        <= '0;
            ycnt_q        <= '0;
            ofv_q         <= 1'b0;
            olv_q         <= 1'b0;
            odata_q       <= '0;
            ox_q          <= '0;
            oy_q          <= '0;
            sig_en_o_q    <= 1'b0;
            sig_out_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            line_pixels_q <= '0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            fv_prev_q     <= fv_prev_d;
            lv_prev_q     <= lv_prev_d;
            xcnt_q        <= xcnt_d;
            ycnt_q        <= ycnt_d;
            ofv_q         <= ofv_d;
            olv_q         <= olv_d;
            odata_q       <= odata_d;
            ox_q          <= ox_d;
            oy_q          <= oy_d;
            sig_en_o_q    <= sig_en_o_d;
            sig_out_q     <= sig_out_d;
            frame_done_q  <= frame_done_d;
            line_pixels_q <= line_pixels_d;
            ovf_q         <= ovf_d;
        end
    end

    assign oFValid     = ofv_q;
    assign oLValid     = olv_q;
    assign odata       = odata_q;
    assign ox          = ox_q;
    assign oy          = oy_q;
    assign sig_en_o    = sig_en_o_q;
    assign sig_out     = sig_out_q;
    assign frame_done  = frame_done_q;
    assign line_pixels = line_pixels_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_tp_frame_capture.sv
// Bench for tp_frame_capture: directed and random frames applied to a default
// MODE=2 instance and a narrow-column MODE=0 instance; expectations come from
// the frame geometry generated by the bench.
module tb_tp_frame_capture;

    localparam int unsigned DW  = 12;
    localparam int unsigned XW  = 12;
    localparam int unsigned YW  = 12;
    localparam int unsigned XW3 = 3;

    logic clk = 1'b0;
    logic rst, en, ina, inb, fv, lv;
    logic [DW-1:0] data;

    logic          oFValid, oLValid, sig_en_o, sig_out, frame_done, ovf;
    logic [DW-1:0] odata;
    logic [XW-1:0] ox, line_pixels;
    logic [YW-1:0] oy;

    logic           oFValid3, oLValid3, sig_en_o3, sig_out3, frame_done3, ovf3;
    logic [DW-1:0]  odata3;
    logic [XW3-1:0] ox3, line_pixels3;
    logic [YW-1:0]  oy3;

    int n_vec = 0;
    int n_err = 0;

    // expected holding values
    int e_ox = 0, e_oy = 0, e_lp = 0, e_ox3 = 0, e_lp3 = 0;
    bit e_ovf3 = 0, e_so2 = 0, e_so0 = 0;
    // frame-level model state
    bit m_cap = 0, m_was_pix = 0, m_waiting = 0, m_en_seen = 0;
    int m_np = 0;

    always #5 clk = ~clk;

    tp_frame_capture #(.DATA_WIDTH(DW), .X_WIDTH(XW), .Y_WIDTH(YW), .MODE(2)) dut (
        .sig_clock(clk), .sig_reset(rst), .sig_en_i(en), .sig_ina(ina), .sig_inb(inb),
        .iFValid(fv), .iLValid(lv), .idata(data),
        .oFValid(oFValid), .oLValid(oLValid), .odata(odata), .ox(ox), .oy(oy),
        .sig_en_o(sig_en_o), .sig_out(sig_out), .frame_done(frame_done),
        .line_pixels(line_pixels), .ovf(ovf)
    );

    tp_frame_capture #(.DATA_WIDTH(DW), .X_WIDTH(XW3), .Y_WIDTH(YW), .MODE(0)) dut3 (
        .sig_clock(clk), .sig_reset(rst), .sig_en_i(en), .sig_ina(ina), .sig_inb(inb),
        .iFValid(fv), .iLValid(lv), .idata(data),
        .oFValid(oFValid3), .oLValid(oLValid3), .odata(odata3), .ox(ox3), .oy(oy3),
        .sig_en_o(sig_en_o3), .sig_out(sig_out3), .frame_done(frame_done3),
        .line_pixels(line_pixels3), .ovf(ovf3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    task automatic check_all(input bit xfv, input bit xlv, input int xd, input bit xen, input bit xdone);
        check("oFValid",      32'(oFValid),      32'(xfv));
        check("oLValid",      32'(oLValid),      32'(xlv));
        check("odata",        32'(odata),        32'(xd));
        check("ox",           32'(ox),           32'(e_ox));
        check("oy",           32'(oy),           32'(e_oy));
        check("sig_en_o",     32'(sig_en_o),     32'(xen));
        check("frame_done",   32'(frame_done),   32'(xdone));
        check("line_pixels",  32'(line_pixels),  32'(e_lp));
        check("ovf",          32'(ovf),          32'(0));
        check("sig_out_xor",  32'(sig_out),      32'(e_so2));
        check("oFValid_n",    32'(oFValid3),     32'(xfv));
        check("oLValid_n",    32'(oLValid3),     32'(xlv));
        check("odata_n",      32'(odata3),       32'(xd));
        check("ox_n",         32'(ox3),          32'(e_ox3));
        check("oy_n",         32'(oy3),          32'(e_oy));
        check("sig_en_o_n",   32'(sig_en_o3),    32'(xen));
        check("frame_done_n", 32'(frame_done3),  32'(xdone));
        check("line_pix_n",   32'(line_pixels3), 32'(e_lp3));
        check("ovf_n",        32'(ovf3),         32'(e_ovf3));
        check("sig_out_and",  32'(sig_out3),     32'(e_so0));
    endtask

    task automatic step(input bit f, input bit l, input logic [DW-1:0] d, input bit a, input bit b);
        fv = f; lv = l; data = d; ina = a; inb = b;
        e_so2 = a ^ b;
        e_so0 = a & b;
        if (en) m_en_seen = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle and pulse reset in the middle of it
    task automatic step_rst(input bit f, input bit l, input logic [DW-1:0] d, input bit a, input bit b);
        fv = f; lv = l; data = d; ina = a; inb = b;
        #1 rst = 1'b1;
        #1;
        e_ox = 0; e_oy = 0; e_lp = 0; e_ox3 = 0; e_lp3 = 0; e_ovf3 = 0;
        e_so2 = 0; e_so0 = 0;
        check_all(0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        e_so2 = a ^ b;
        e_so0 = a & b;
        m_cap = 1'b0;
        m_en_seen = en;
        @(posedge clk);
        #1;
    endtask

    task automatic blank_cycle();
        step(1, 0, DW'($urandom), rb(), rb());
        if (m_cap && m_was_pix) begin
            e_lp  = m_np;
            e_lp3 = sat7(m_np);
        end
        m_was_pix = 0;
        check_all(m_cap, 0, 0, m_cap, 0);
    endtask

    task automatic pixel_cycle(input int r, input int c, input logic [DW-1:0] d, input bit do_rst);
        if (do_rst) begin
            step_rst(1, 1, d, rb(), rb());
            m_was_pix = 0;
            check_all(0, 0, 0, 0, 0);
        end else begin
            step(1, 1, d, rb(), rb());
            if (m_cap) begin
                e_ox  = c;
                e_oy  = r;
                e_ox3 = sat7(c);
                if (c >= 7) e_ovf3 = 1;
            end
            m_was_pix = 1;
            check_all(m_cap, m_cap, m_cap ? int'(d) : 0, m_cap, 0);
        end
    endtask

    // One frame: lead-in idle, optional porch, nl lines of np pixels, end of frame
    task automatic run_frame(input int nl, input int np, input int gap, input int fp, input int bp,
                             input int lead, input bit seq, input bit en_lead, input bit en_mid,
                             input int rst_at);
        int pix;
        logic [DW-1:0] d;
        m_cap     = m_waiting || en_lead;
        m_np      = np;
        m_was_pix = 0;
        m_en_seen = 0;
        en        = en_lead;
        for (int i = 0; i < lead; i++) begin
            step(0, (i == lead - 1) ? 1'b0 : rb(), DW'($urandom), rb(), rb());
            check_all(0, 0, 0, 0, 0);
        end
        if (m_cap) e_ovf3 = 0;
        for (int i = 0; i < fp; i++) blank_cycle();
        pix = 0;
        for (int r = 0; r < nl; r++) begin
            for (int c = 0; c < np; c++) begin
                d = seq ? DW'(r * np + c + 1) : DW'($urandom);
                pixel_cycle(r, c, d, pix == rst_at);
                pix++;
            end
            if (r == 0) en = en_mid;
            for (int k = 0; k < ((r < nl - 1) ? gap : bp); k++) blank_cycle();
        end
        step(0, 0, DW'($urandom), rb(), rb());
        if (m_cap && m_was_pix) begin
            e_lp  = np;
            e_lp3 = sat7(np);
        end
        check_all(0, 0, 0, 0, m_cap);
        m_waiting = m_cap ? 1'b0 : m_en_seen;
    endtask

    initial begin
        int nl, np;
        rst = 1'b0; en = 1'b0; ina = 1'b0; inb = 1'b0; fv = 1'b0; lv = 1'b0; data = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all(0, 0, 0, 0, 0);
        rst = 1'b0;

        // logic output in IDLE: operands 00,01,10,11
        for (int k = 0; k < 4; k++) begin
            step(0, 0, DW'($urandom), k[1], k[0]);
            check_all(0, 0, 0, 0, 0);
        end

        // 3 lines x 4 pixels, data 1..12, 2-cycle gaps
        run_frame(3, 4, 2, 1, 1, 3, 1, 1, 1, -1);
        // disarm while active, frame ends with line still open
        run_frame(2, 3, 1, 0, 0, 2, 0, 1, 0, -1);
        // arm in the middle of a frame: not captured
        run_frame(2, 4, 1, 1, 1, 3, 0, 0, 1, -1);
        // following frame captured even with enable low
        run_frame(2, 4, 1, 0, 1, 3, 1, 0, 1, -1);
        // 10-pixel line saturates the narrow column counter
        run_frame(1, 10, 1, 0, 1, 3, 1, 1, 1, -1);
        // next frame start clears the overflow flag
        run_frame(2, 3, 1, 1, 1, 3, 0, 1, 1, -1);
        // reset at pixel 5 of a 4x3 frame, then a clean frame
        run_frame(3, 4, 2, 1, 1, 3, 1, 1, 1, 4);
        run_frame(3, 4, 2, 1, 1, 3, 1, 1, 1, -1);

        for (int f = 0; f < 40; f++) begin
            nl = $urandom_range(1, 4);
            np = $urandom_range(1, 12);
            run_frame(nl, np, $urandom_range(1, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(2, 4), 0, ($urandom_range(0, 3) != 0), rb(),
                      ($urandom_range(0, 9) == 0) ? $urandom_range(0, nl * np - 1) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
